div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter_if.sv | 43 ++++
 rtl/div_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if
// Bundles everything between the arbiter, its two requesters and the shared
// divider.
//   Requester side : req0/req1, a0/b0/a1/b1 in; ack0/ack1, vld0/vld1 and
//                    res0/res1 back out.
//   Divider side   : div_init, div_a, div_b out; div_done, div_result in.
//   Status         : busy, err.
// Modports:
//   slave  : the arbiter itself.
//   master : the environment, i.e. the requesters plus the divider.
interface div_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] a0;
  logic [15:0] b0;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        ack0;
  logic        ack1;
  logic        vld0;
  logic        vld1;
  logic [31:0] res0;
  logic [31:0] res1;
  logic        div_init;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic        div_done;
  logic [31:0] div_result;
  logic        busy;
  logic        err;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, div_done, div_result,
    output ack0, ack1, vld0, vld1, res0, res1, div_init, div_a, div_b,
           busy, err
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, div_done, div_result,
    input  ack0, ack1, vld0, vld1, res0, res1, div_init, div_a, div_b,
           busy, err
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter
// Shares a single divider between two requesters. A granted job has its
// operands captured; a zero divisor is answered directly with all-ones,
// otherwise the divider is started and its result is forwarded back. A job
// the divider does not finish within TIMEOUT cycles is aborted with all-ones
// and sets the sticky err flag. One idle GAP cycle always separates two jobs.
// Ports:
//   clk   : rising-edge clock.
//   reset : asynchronous, active-high reset.
//   bus   : div_arbiter_if.slave carrying the requester, divider and status
//           signals.
module div_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  div_arbiter_if.slave   bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DZ, GAP} state_t;

  state_t        state, state_n;
  logic          last, last_n;
  logic          cur, cur_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ack0, ack0_n;
  logic          ack1, ack1_n;
  logic          vld0, vld0_n;
  logic          vld1, vld1_n;
  logic          div_init, div_init_n;
  logic          err, err_n;
  logic [15:0]   div_a, div_a_n;
  logic [15:0]   div_b, div_b_n;
  logic [31:0]   res0, res0_n;
  logic [31:0]   res1, res1_n;

  logic          pick;
  logic [15:0]   sel_a;
  logic [15:0]   sel_b;
  logic          fin;
  logic [31:0]   fin_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      cur      <= 1'b0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      vld0     <= 1'b0;
      vld1     <= 1'b0;
      div_init <= 1'b0;
      err      <= 1'b0;
      div_a    <= '0;
      div_b    <= '0;
      res0     <= '0;
      res1     <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      cur      <= cur_n;
      cnt      <= cnt_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      vld0     <= vld0_n;
      vld1     <= vld1_n;
      div_init <= div_init_n;
      err      <= err_n;
      div_a    <= div_a_n;
      div_b    <= div_b_n;
      res0     <= res0_n;
      res1     <= res1_n;
    end
  end

  always_comb begin
    state_n    = state;
    last_n     = last;
    cur_n      = cur;
    cnt_n      = cnt;
    ack0_n     = 1'b0;
    ack1_n     = 1'b0;
    vld0_n     = 1'b0;
    vld1_n     = 1'b0;
    div_init_n = div_init;
    err_n      = err;
    div_a_n    = div_a;
    div_b_n    = div_b;
    res0_n     = res0;
    res1_n     = res1;
    fin        = 1'b0;
    fin_res    = 32'hFFFF_FFFF;

    // On a tie the requester not served last wins; otherwise whoever asks.
    pick  = (bus.req0 && bus.req1) ? ~last : bus.req1;
    sel_a = pick ? bus.a1 : bus.a0;
    sel_b = pick ? bus.b1 : bus.b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          div_a_n = sel_a;
          div_b_n = sel_b;
          ack0_n  = ~pick;
          ack1_n  = pick;
          last_n  = pick;
          cur_n   = pick;
          cnt_n   = '0;
          if (sel_b != 16'd0) begin
            div_init_n = 1'b1;
            state_n    = WAIT;
          end else begin
            state_n = DZ;
          end
        end
      end
      WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (bus.div_done) begin
          fin     = 1'b1;
          fin_res = bus.div_result;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fin   = 1'b1;
          err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DZ: begin
        fin = 1'b1;
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (fin) begin
      div_init_n = 1'b0;
      cnt_n      = '0;
      state_n    = GAP;
      if (cur) begin
        res1_n = fin_res;
        vld1_n = 1'b1;
      end else begin
        res0_n = fin_res;
        vld0_n = 1'b1;
      end
    end
  end

  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.vld0     = vld0;
  assign bus.vld1     = vld1;
  assign bus.res0     = res0;
  assign bus.res1     = res1;
  assign bus.div_init = div_init;
  assign bus.div_a    = div_a;
  assign bus.div_b    = div_b;
  assign bus.err      = err;
  assign bus.busy     = (state != IDLE);

endmodule
